superio_reg_bank: RTL and testbench
===================================

# superio_reg_bank

Parametrised Avalon-MM register bank for the Super I/O riser logic, replacing the fixed three-register tri-state read mux. It holds NUM_REGS writable control registers, and returns either those registers or live status inputs on reads. Read data is driven through a configurable-latency pipeline with readdatavalid instead of tri-stating the bus. It sits between the QSYS interconnect and the Super I/O function blocks, which consume reg_out and supply status_in.

## Interface
- WIDTH, 32: data width in bits; must be a multiple of 8.
- NUM_REGS, 8: number of registers, 2..16.
- ADDR_WIDTH, 4: word-address width; 2**ADDR_WIDTH >= NUM_REGS.
- READ_LATENCY, 1: cycles from read acceptance to readdatavalid, 1..4.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only status (reads status_in slice i, writes ignored).
- RESET_VALUE, 0: WIDTH-bit reset value loaded into every writable register.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_WIDTH  word address.
- chipselect  in  1  qualifies read/write.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  WIDTH  write data.
- byteenable  in  WIDTH/8  per-byte write enables.
- readdata  out  WIDTH  registered read data.
- readdatavalid  out  1  readdata valid strobe.
- reg_out  out  NUM_REGS*WIDTH  flat writable-register contents; slice i = [i*WIDTH +: WIDTH].
- status_in  in  NUM_REGS*WIDTH  flat live status inputs, same slicing.
- rd_strobe  out  NUM_REGS  one-hot read side-effect pulse.

## Operation
- A read is accepted on a rising edge with chipselect=1, read=1. A write is accepted on a rising edge with chipselect=1, write=1. No waitrequest exists: every request is accepted.
- Write: for a writable register at address < NUM_REGS, byte k is updated iff byteenable[k]=1. Writes to RO registers or to address >= NUM_REGS are silently dropped.
- Read source: status_in slice if RO_MASK[i]=1, else the reg_out slice. Address >= NUM_REGS returns all zeros, still with readdatavalid.
- Read data is sampled at the accepting edge and shifted through a READ_LATENCY-deep pipeline of {valid, data}. Back-to-back reads are fully pipelined, one per cycle, and return in order.
- Simultaneous read and write in the same cycle: both are performed. If the addresses match, the read returns the pre-write value.
- read=1 and write=1 with the same address is legal; the same rule applies.
- reset: reg_out = RESET_VALUE for every writable slice (RO slices of reg_out are 0); readdata=0; readdatavalid=0; rd_strobe=0. The pipeline is flushed, so a read in flight at reset never produces readdatavalid.

## Timing
- Write visible on reg_out the cycle after the accepting edge.
- Read accepted at edge N gives readdatavalid=1 and readdata during the cycle following edge N+READ_LATENCY-1 (READ_LATENCY=1: the cycle right after acceptance).
- readdatavalid is high for exactly one cycle per accepted read.
- readdata holds its last value when readdatavalid=0.
- status_in is sampled at the accepting edge only; later changes do not affect the in-flight result.

## Configuration
- SUPERIO_REGBANK_RDSTROBE_EN defined: rd_strobe[i] is high for exactly one cycle following the edge that accepts a read of address i < NUM_REGS. Status producers use it for clear-on-read. There is no strobe for out-of-range addresses.
- Not defined: rd_strobe is tied to 0 and no strobe logic is generated. Read data behaviour is identical either way.

## Test plan
- Reset, then read all addresses: reg_out slices = RESET_VALUE (RO slices 0). Each read returns RESET_VALUE or status_in with readdatavalid after READ_LATENCY cycles. Address NUM_REGS returns 0x00000000 with valid.
- Write 0xDEADBEEF to reg 2 with byteenable=4'b0101 over 0x11223344: reg 2 reads 0x11AD33EF. A write to an RO register leaves its readback equal to status_in.
- READ_LATENCY=3: four back-to-back reads of regs 0..3 give four consecutive readdatavalid pulses, in order, starting 3 cycles after the first acceptance.
- Same-cycle read+write of reg 1 (old 0x5, new 0xA): read returns 0x5, and the next read returns 0xA.
- Assert reset while two reads are in flight (READ_LATENCY=4): no readdatavalid ever appears, and all outputs take their reset values immediately.
- With SUPERIO_REGBANK_RDSTROBE_EN: reading reg 3 gives rd_strobe=0x0008 for one cycle, and an out-of-range read gives no strobe. Without the macro, rd_strobe stays 0 throughout.

Source files
------------

// File: rtl/superio_reg_bank.sv
// Avalon-MM register bank for the Super I/O riser: writable control registers, RO status
// passthrough, pipelined reads with readdatavalid. Optional macro: SUPERIO_REGBANK_RDSTROBE_EN.

module superio_reg_slot #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   writedata,
    input  logic [WIDTH/8-1:0] byteenable,
    output logic [WIDTH-1:0]   q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (wr_en) begin
            for (int k = 0; k < WIDTH/8; k++)
                if (byteenable[k]) q[k*8 +: 8] <= writedata[k*8 +: 8];
        end
    end
endmodule

module superio_reg_bank #(
    parameter int                  WIDTH        = 32,
    parameter int                  NUM_REGS     = 8,
    parameter int                  ADDR_WIDTH   = 4,
    parameter int                  READ_LATENCY = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK      = '0,
    parameter logic [WIDTH-1:0]    RESET_VALUE  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [WIDTH-1:0]          writedata,
    input  logic [WIDTH/8-1:0]        byteenable,
    output logic [WIDTH-1:0]          readdata,
    output logic                      readdatavalid,
    output logic [NUM_REGS*WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]       rd_strobe
);
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] rd_data;

    assign rd_acc = chipselect & read;
    assign wr_acc = chipselect & write;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_out[i*WIDTH +: WIDTH] = '0;
        end else begin : g_rw
            superio_reg_slot #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .wr_en      (wr_acc && (int'(address) == i)),
                .writedata  (writedata),
                .byteenable (byteenable),
                .q          (reg_out[i*WIDTH +: WIDTH])
            );
        end
    end

    // Mux reads from reg_out before the write lands, so a same-address read sees the old value.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (int'(address) == i)
                rd_data = RO_MASK[i] ? status_in[i*WIDTH +: WIDTH] : reg_out[i*WIDTH +: WIDTH];
    end

    // Stage 0 is the accepting edge's input; each stage's data only loads behind a valid,
    // so the last stage naturally holds the most recent returned word.
    logic [READ_LATENCY-1:0]            vld_q;
    logic [READ_LATENCY-1:0][WIDTH-1:0] dat_q;
    logic [READ_LATENCY:0]              vld_pipe;
    logic [READ_LATENCY:0][WIDTH-1:0]   dat_pipe;

    assign vld_pipe = {vld_q, rd_acc};
    assign dat_pipe = {dat_q, rd_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_pipe[READ_LATENCY-1:0];
            for (int k = 0; k < READ_LATENCY; k++)
                if (vld_pipe[k]) dat_q[k] <= dat_pipe[k];
        end
    end

    assign readdatavalid = vld_pipe[READ_LATENCY];
    assign readdata      = dat_pipe[READ_LATENCY];

`ifdef SUPERIO_REGBANK_RDSTROBE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_strobe <= '0;
        end else begin
            rd_strobe <= '0;
            if (rd_acc)
                for (int i = 0; i < NUM_REGS; i++)
                    if (int'(address) == i) rd_strobe[i] <= 1'b1;
        end
    end
`else
    assign rd_strobe = '0;
`endif

endmodule

// File: tb/tb_superio_reg_bank.sv
// Scoreboard bench for superio_reg_bank (READ_LATENCY=3, regs 5 and 7 read-only);
// strobe expectations follow SUPERIO_REGBANK_RDSTROBE_EN.

module tb_superio_reg_bank;
    localparam int          W   = 32;
    localparam int          N   = 8;
    localparam int          AW  = 4;
    localparam int          RL  = 3;
    localparam logic [N-1:0] RO = 8'b1010_0000;
    localparam logic [W-1:0] RV = 32'hA5A5_0001;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   address;
    logic            chipselect, read, write;
    logic [W-1:0]    writedata;
    logic [W/8-1:0]  byteenable;
    logic [W-1:0]    readdata;
    logic            readdatavalid;
    logic [N*W-1:0]  reg_out;
    logic [N*W-1:0]  status_in;
    logic [N-1:0]    rd_strobe;

    superio_reg_bank #(
        .WIDTH(W), .NUM_REGS(N), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
        .RO_MASK(RO), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid), .reg_out(reg_out),
        .status_in(status_in), .rd_strobe(rd_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   vcount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per readdatavalid and checks data and arrival cycle.
    always @(negedge clk) begin
        if (readdatavalid === 1'b1) begin
            exp_t e;
            vcount++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got data %h at cycle %0d expected no valid", readdata, cyc);
            end else begin
                e = q.pop_front();
                if (readdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL read_return: got %h at cycle %0d expected %h at cycle %0d",
                             readdata, cyc, e.data, e.due);
                end
            end
        end
    end

    function automatic logic [N-1:0] exp_strobe(input int a);
`ifdef SUPERIO_REGBANK_RDSTROBE_EN
        logic [N-1:0] s;
        s = '0;
        if (a < N) s[a] = 1'b1;
        return s;
`else
        return '0;
`endif
    endfunction

    // All tasks start and end at a falling edge.
    task automatic rd(input int a, input logic [W-1:0] exp, input bit push);
        exp_t e;
        address = AW'(a); chipselect = 1'b1; read = 1'b1; write = 1'b0;
        e.data = exp; e.due = cyc + RL;
        if (push) q.push_back(e);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        chk($sformatf("rd_strobe_a%0d", a), W'(rd_strobe), W'(exp_strobe(a)));
    endtask

    task automatic wr(input int a, input logic [W-1:0] d, input logic [W/8-1:0] be);
        address = AW'(a); chipselect = 1'b1; write = 1'b1; read = 1'b0;
        writedata = d; byteenable = be;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rw(input int a, input logic [W-1:0] d, input logic [W-1:0] exp);
        exp_t e;
        address = AW'(a); chipselect = 1'b1; write = 1'b1; read = 1'b1;
        writedata = d; byteenable = '1;
        e.data = exp; e.due = cyc + RL;
        q.push_back(e);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] rst_img;
        int             v0;
        reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0;
        for (int i = 0; i < N; i++) status_in[i*W +: W] = 32'h5000_0000 | i;
        for (int i = 0; i < N; i++) rst_img[i*W +: W] = RO[i] ? '0 : RV;

        repeat (2) @(negedge clk);
        checks++;
        if (reg_out !== rst_img) begin
            errors++;
            $display("FAIL reset_reg_out: got %h expected %h", reg_out, rst_img);
        end
        chk("reset_readdata", readdata, '0);
        chk("reset_valid", W'(readdatavalid), '0);
        chk("reset_strobe", W'(rd_strobe), '0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back reads of every address plus two out-of-range ones
        for (int a = 0; a < N; a++) rd(a, RO[a] ? (32'h5000_0000 | a) : RV, 1'b1);
        rd(8, 32'h0, 1'b1);
        rd(15, 32'h0, 1'b1);
        repeat (4) @(negedge clk);

        // Byte-enabled write
        wr(2, 32'h1122_3344, 4'hF);
        chk("reg2_full_write", reg_out[2*W +: W], 32'h1122_3344);
        wr(2, 32'hDEAD_BEEF, 4'b0101);
        chk("reg2_byte_write", reg_out[2*W +: W], 32'h11AD_33EF);
        rd(2, 32'h11AD_33EF, 1'b1);

        // RO write ignored; out-of-range write must not alias onto reg 1
        wr(5, 32'hFFFF_FFFF, 4'hF);
        chk("ro_reg_out_zero", reg_out[5*W +: W], '0);
        rd(5, 32'h5000_0005, 1'b1);
        wr(9, 32'hFFFF_FFFF, 4'hF);
        rd(1, RV, 1'b1);

        // status_in is sampled only at the accepting edge
        rd(7, 32'h5000_0007, 1'b1);
        status_in[7*W +: W] = 32'hCAFE_0007;
        rd(7, 32'hCAFE_0007, 1'b1);

        // Same-cycle read+write returns the pre-write value
        wr(1, 32'h5, 4'hF);
        rw(1, 32'hA, 32'h5);
        chk("rw_new_value", reg_out[1*W +: W], 32'hA);
        rd(1, 32'hA, 1'b1);
        rd(3, RV, 1'b1);
        repeat (6) @(negedge clk);
        chk("readdata_hold", readdata, RV);
        chk("valid_idle", W'(readdatavalid), '0);

        // Reset with two reads in flight: nothing may come back
        rd(0, RV, 1'b0);
        rd(1, 32'hA, 1'b0);
        v0 = vcount;
        reset = 1'b1;
        #1;
        chk("inflight_reset_valid", W'(readdatavalid), '0);
        chk("inflight_reset_readdata", readdata, '0);
        chk("inflight_reset_reg1", reg_out[1*W +: W], RV);
        chk("inflight_reset_strobe", W'(rd_strobe), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("inflight_valid_count", W'(vcount - v0), '0);

        for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL read_timeout: got %0d reads outstanding expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
